le_cluster: RTL and testbench
=============================

// Module: le_cluster
// PURPOSE
//  Parametrised successor of the single logic element: NUM_LE K-input LUT elements sharing one
//  config daisy-chain. Adds double-buffered config (shadow + active), a bit counter with commit
//  validation, a configurable FF init value and one clock for config and fabric. Sits in the
//  fabric tile between connection boxes (sel_cb) and local interconnect (sel_lei).
// PARAMETERS
//  NUM_LE   4   logic elements in the cluster
//  LUT_K    4   inputs per LUT; LUT_SIZE = 2**LUT_K
//  (derived) FRAME_W = LUT_SIZE+2 bits per LE; CFG_W = NUM_LE*FRAME_W
// PORTS
//  clk              in   1               single clock, rising edge, config and fabric
//  nrst             in   1               asynchronous active-low reset
//  config_en        in   1               shift config_data_in into the shadow chain this cycle
//  config_data_in   in   1               serial config bit, MSB first
//  config_data_out  out  1               shadow[CFG_W-1]; daisy-chains to next cluster
//  config_commit    in   1               copy shadow to active config (if cfg_done)
//  cfg_done         out  1               exactly CFG_W bits shifted since reset/commit
//  cfg_err          out  1               sticky: commit requested while cfg_done=0
//  le_en            in   1               FF enable, all LEs
//  sel_cb           in   NUM_LE*LUT_K    LUT inputs from connection box, LE i at [i*LUT_K +: LUT_K]
//  sel_lei          in   NUM_LE*LUT_K    LUT inputs from local interconnect, same packing
//  lei_dvn          in   NUM_LE*LUT_K    per-bit source select: 1=sel_lei, 0=sel_cb
//  le_out           out  NUM_LE          LE outputs
// BEHAVIOUR
//  - Reset (nrst=0, async): shadow, active, FFs, bit counter, cfg_err cleared; all outputs 0.
//  - Shift: config_en=1 -> shadow <= {shadow[CFG_W-2:0], config_data_in}. The bit counter
//    increments, saturating at CFG_W+1. cfg_done = (count == CFG_W).
//  - Frame layout: LE i = shadow[i*FRAME_W +: FRAME_W]. Bit FRAME_W-1 = reg_mode;
//    bit FRAME_W-2 = ff_init; [LUT_SIZE-1:0] = lut. The LE[NUM_LE-1] frame is sent first.
//  - Commit: config_commit=1 and cfg_done=1 -> active <= shadow on that edge; all FFs load their
//    new ff_init, regardless of le_en; counter <= 0. New config drives le_out from the next cycle.
//  - Commit with cfg_done=0: ignored (active, FFs, counter unchanged); cfg_err <= 1, cleared
//    only by reset.
//  - Commit and config_en in the same cycle: the commit uses the pre-shift shadow. The shift still
//    occurs. The counter becomes 1 (commit accepted) or increments (commit rejected).
//  - Effective LUT select, per bit: lei_dvn ? sel_lei : sel_cb. lut_val = active.lut[sel].
//  - reg_mode=0: le_out = lut_val, combinational, same cycle.
//  - reg_mode=1: le_out = FF. With le_en=1, FF <= lut_val each edge (1-cycle latency).
//    With le_en=0, the FF holds.
//  - Priority on the FF: nrst > accepted commit > le_en.
//  - Shadow shifting never disturbs active config or le_out; reconfigure while running.
//  - config_data_out is shadow MSB (registered); a CFG_W-cycle delay of config_data_in.
// STRUCTURE
//  - le_pkg: localparams/functions for LUT_SIZE, FRAME_W, CFG_W, field offsets (REG_MODE_BIT,
//    FF_INIT_BIT); typedef struct packed le_cfg_t {reg_mode, ff_init, lut}.
//  - Sub-module le_cell, NUM_LE instances: input mux, LUT read, FF with enable/init load.
//    le_cluster owns the shadow chain, active registers, counter, cfg_done/cfg_err.
// TESTING (NUM_LE=4, LUT_K=4, CFG_W=72)
//  1. Shift 72 bits, each LE lut=16'h6996 (XOR), reg_mode=0, then commit. Sweep sel_cb 0..15,
//     lei_dvn=0 -> le_out[i] = ^sel each cycle.
//  2. Same config with lei_dvn='1; drive sel_lei 0..15 and sel_cb=~sel_lei -> outputs follow
//     sel_lei. Mixed lei_dvn=4'b0101 selects per bit.
//  3. LE0: reg_mode=1, ff_init=1, lut=16'h0001. Commit -> le_out[0]=1 the cycle after commit.
//     sel_cb=0, le_en=1 -> stays 1. le_en=0, sel=1 -> holds 1 for 10 cycles.
//     le_en=1 -> 0 the next cycle.
//  4. Shift 71 bits then commit -> active unchanged, le_out unchanged, cfg_err=1, cfg_done=0.
//     One more bit -> cfg_done=1; commit accepted; cfg_err stays 1.
//  5. Running config A; shift config B without commit -> le_out still A. Commit with config_en=1
//     the same cycle -> B active the next cycle; count=1. config_data_out matches input delayed
//     72 cycles.
//  6. Assert nrst mid-shift, between edges -> le_out, cfg_done, cfg_err and config_data_out = 0
//     immediately. After release, a full 72-bit reload + commit works.

Source files
------------

// File: rtl/le_pkg.sv
// Shared sizing helpers, frame field offsets and the per-LE config frame layout.
package le_pkg;

    localparam int DEF_NUM_LE = 4;
    localparam int DEF_LUT_K  = 4;

    // Number of truth-table entries in a K-input LUT
    function automatic int lutSize(input int k);
        return 1 << k;
    endfunction

    // One LE frame is the truth table plus the reg_mode and ff_init bits
    function automatic int frameW(input int k);
        return lutSize(k) + 2;
    endfunction

    // Total length of the cluster's config chain
    function automatic int cfgW(input int n, input int k);
        return n * frameW(k);
    endfunction

    // Bit offsets of the control fields inside one LE frame
    function automatic int regModeBit(input int k);
        return frameW(k) - 1;
    endfunction

    function automatic int ffInitBit(input int k);
        return frameW(k) - 2;
    endfunction

    localparam int LUT_SIZE     = lutSize(DEF_LUT_K);
    localparam int FRAME_W      = frameW(DEF_LUT_K);
    localparam int CFG_W        = cfgW(DEF_NUM_LE, DEF_LUT_K);
    localparam int REG_MODE_BIT = regModeBit(DEF_LUT_K);
    localparam int FF_INIT_BIT  = ffInitBit(DEF_LUT_K);

    // Frame of one LE at the default LUT size, MSB first as it travels the chain
    typedef struct packed {
        logic                reg_mode;
        logic                ff_init;
        logic [LUT_SIZE-1:0] lut;
    } le_cfg_t;

endpackage

// File: rtl/le_cell.sv
// One logic element: per-bit LUT input source mux, LUT read, and an output FF
// that loads its init value on an accepted commit.
module le_cell
    import le_pkg::*;
#(
    parameter int LUT_K = 4
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [frameW(LUT_K)-1:0]  cfg_i,
    input  logic                      commit_i,
    input  logic                      initVal_i,
    input  logic                      en_i,
    input  logic [LUT_K-1:0]          selCb_i,
    input  logic [LUT_K-1:0]          selLei_i,
    input  logic [LUT_K-1:0]          leiDvn_i,
    output logic                      out_o
);

    localparam int LUT_SIZE = lutSize(LUT_K);

    logic [LUT_K-1:0]    selEff;
    logic [LUT_SIZE-1:0] lutBits;
    logic                regMode;
    logic                lutVal;
    logic                ff_q;
    logic                ff_d;

    assign selEff  = (leiDvn_i & selLei_i) | (~leiDvn_i & selCb_i);
    assign lutBits = cfg_i[LUT_SIZE-1:0];
    assign regMode = cfg_i[regModeBit(LUT_K)];
    assign lutVal  = lutBits[selEff];

    // FF next state: a commit reloads the init value even when the FF is disabled
    always_comb begin
        ff_d = ff_q;
        if (commit_i) begin
            ff_d = initVal_i;
        end else if (en_i) begin
            ff_d = lutVal;
        end
    end

    // Output FF register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ff_q <= 1'b0;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign out_o = regMode ? ff_q : lutVal;

endmodule

// File: rtl/le_cluster.sv
// Cluster of LUT logic elements sharing one serial config chain. Config is
// shifted into a shadow copy and only becomes active on a validated commit,
// so the fabric keeps running while the next configuration streams in.
module le_cluster
    import le_pkg::*;
#(
    parameter int NUM_LE = 4,
    parameter int LUT_K  = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    config_en,
    input  logic                    config_data_in,
    output logic                    config_data_out,
    input  logic                    config_commit,
    output logic                    cfg_done,
    output logic                    cfg_err,
    input  logic                    le_en,
    input  logic [NUM_LE*LUT_K-1:0] sel_cb,
    input  logic [NUM_LE*LUT_K-1:0] sel_lei,
    input  logic [NUM_LE*LUT_K-1:0] lei_dvn,
    output logic [NUM_LE-1:0]       le_out
);

    localparam int FRAME_W = frameW(LUT_K);
    localparam int CFG_W   = cfgW(NUM_LE, LUT_K);
    localparam int CNT_W   = $clog2(CFG_W + 2);

    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CFG_W-1:0] shadow_q;
    logic [CFG_W-1:0] shadow_d;
    logic [CFG_W-1:0] active_q;
    logic [CNT_W-1:0] bitCount_q;
    logic [CNT_W-1:0] bitCount_d;
    logic             cfgErr_q;
    logic             commitOk;

    assign cfg_done        = (bitCount_q == CNT_DONE);
    assign cfg_err         = cfgErr_q;
    assign commitOk        = config_commit & cfg_done;
    assign config_data_out = shadow_q[CFG_W-1];

    // Shadow chain shifts MSB-first; the last LE's frame ends up at the top
    always_comb begin
        shadow_d = shadow_q;
        if (config_en) begin
            shadow_d = {shadow_q[CFG_W-2:0], config_data_in};
        end
    end

    // Bit counter: restarts on an accepted commit (counting a same-cycle shift), saturates past full
    always_comb begin
        bitCount_d = bitCount_q;
        if (commitOk) begin
            bitCount_d = config_en ? CNT_ONE : '0;
        end else if (config_en && (bitCount_q != CNT_MAX)) begin
            bitCount_d = bitCount_q + CNT_ONE;
        end
    end

    // Shadow chain and bit counter registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shadow_q   <= '0;
            bitCount_q <= '0;
        end else begin
            shadow_q   <= shadow_d;
            bitCount_q <= bitCount_d;
        end
    end

    // Active config takes the pre-shift shadow on an accepted commit
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            active_q <= '0;
        end else if (commitOk) begin
            active_q <= shadow_q;
        end
    end

    // Sticky error for a commit attempted before a full frame set arrived
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cfgErr_q <= 1'b0;
        end else if (config_commit && !cfg_done) begin
            cfgErr_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LE; i++) begin : g_cell
        le_cell #(
            .LUT_K (LUT_K)
        ) u_cell (
            .clk       (clk),
            .nrst      (nrst),
            .cfg_i     (active_q[i*FRAME_W +: FRAME_W]),
            .commit_i  (commitOk),
            .initVal_i (shadow_q[i*FRAME_W + ffInitBit(LUT_K)]),
            .en_i      (le_en),
            .selCb_i   (sel_cb[i*LUT_K +: LUT_K]),
            .selLei_i  (sel_lei[i*LUT_K +: LUT_K]),
            .leiDvn_i  (lei_dvn[i*LUT_K +: LUT_K]),
            .out_o     (le_out[i])
        );
    end

endmodule

// File: tb/tb_le_cluster.sv
// Scoreboard bench for le_cluster: stimulus queues expected values tagged with
// the cycle they apply to; a negedge monitor pops and compares them.
module tb_le_cluster;
    import le_pkg::*;

    localparam int K_OUT  = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;
    localparam int K_CDO  = 3;

    logic        clk;
    logic        nrst;
    logic        config_en;
    logic        config_data_in;
    logic        config_data_out;
    logic        config_commit;
    logic        cfg_done;
    logic        cfg_err;
    logic        le_en;
    logic [15:0] sel_cb;
    logic [15:0] sel_lei;
    logic [15:0] lei_dvn;
    logic [3:0]  le_out;

    int          cyc = 0;
    int          nChecks = 0;
    int          nPass = 0;

    int          qCyc[$];
    int          qKind[$];
    logic [3:0]  qExp[$];
    string       qName[$];
    bit          sentBits[$];

    le_cluster #(
        .NUM_LE (4),
        .LUT_K  (4)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .config_en       (config_en),
        .config_data_in  (config_data_in),
        .config_data_out (config_data_out),
        .config_commit   (config_commit),
        .cfg_done        (cfg_done),
        .cfg_err         (cfg_err),
        .le_en           (le_en),
        .sel_cb          (sel_cb),
        .sel_lei         (sel_lei),
        .lei_dvn         (lei_dvn),
        .le_out          (le_out)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index used to tag expectations
    always @(posedge clk) cyc <= cyc + 1;

    // Safety net against a hung run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] actualOf(input int kind);
        case (kind)
            K_OUT:   return le_out;
            K_DONE:  return {3'b000, cfg_done};
            K_ERR:   return {3'b000, cfg_err};
            default: return {3'b000, config_data_out};
        endcase
    endfunction

    task automatic checkOutput(input int idx);
        logic [3:0] act;
        act = actualOf(qKind[idx]);
        nChecks++;
        if (act === qExp[idx]) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", qName[idx], act, qExp[idx], qCyc[idx]);
        end
    endtask

    // Monitor: compare every expectation whose cycle has arrived, mid-cycle
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < qCyc.size()) begin
            if (qCyc[i] <= cyc) begin
                checkOutput(i);
                qCyc.delete(i);
                qKind.delete(i);
                qExp.delete(i);
                qName.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic expectNow(input int kind, input logic [3:0] exp, input string name);
        qCyc.push_back(cyc);
        qKind.push_back(kind);
        qExp.push_back(exp);
        qName.push_back(name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] cb, input logic [15:0] lei,
                                 input logic [15:0] dvn, input logic en);
        sel_cb  = cb;
        sel_lei = lei;
        lei_dvn = dvn;
        le_en   = en;
    endtask

    function automatic logic [17:0] mkFrame(input logic rm, input logic fi, input logic [15:0] lut);
        le_cfg_t f;
        f.reg_mode = rm;
        f.ff_init  = fi;
        f.lut      = lut;
        return f;
    endfunction

    function automatic logic expCdo();
        if (sentBits.size() >= 72) return sentBits[sentBits.size() - 72];
        return 1'b0;
    endfunction

    task automatic shiftRange(input logic [71:0] cfg, input int hi, input int lo);
        for (int b = hi; b >= lo; b--) begin
            expectNow(K_CDO, {3'b000, expCdo()}, "config_data_out");
            config_en      = 1'b1;
            config_data_in = cfg[b];
            sentBits.push_back(cfg[b]);
            tick();
        end
        config_en = 1'b0;
    endtask

    task automatic commitConfig();
        config_commit = 1'b1;
        tick();
        config_commit = 1'b0;
    endtask

    initial begin
        logic [17:0] fx;
        logic [71:0] cfgX;
        logic [71:0] cfg3;
        logic [71:0] cfgC;
        logic [71:0] cfgB;
        logic [15:0] cbv;
        logic [15:0] leiv;
        logic [3:0]  expv;
        logic [15:0] mixLei[8];
        logic [15:0] mixCb[8];
        logic [3:0]  mixExp[8];
        int          wait_n;

        mixLei = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0000, 16'h4000, 16'h0000, 16'h0100};
        mixCb  = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 16'h4000, 16'h0000};
        mixExp = '{4'b0000,  4'b0000,  4'b0001,  4'b0000,  4'b0010,  4'b1000,  4'b0000,  4'b0100};

        fx   = mkFrame(1'b0, 1'b0, 16'h6996);
        cfgX = {fx, fx, fx, fx};
        cfg3 = {fx, fx, fx, mkFrame(1'b1, 1'b1, 16'h0001)};
        cfgC = {4{mkFrame(1'b0, 1'b1, 16'h0000)}};
        cfgB = {4{mkFrame(1'b0, 1'b0, 16'hFFFE)}};

        // Reset state
        nrst           = 1'b0;
        config_en      = 1'b0;
        config_data_in = 1'b0;
        config_commit  = 1'b0;
        applyStimulus(16'h1234, 16'h5678, 16'h0000, 1'b0);
        tick();
        expectNow(K_OUT,  4'b0000, "reset le_out");
        expectNow(K_DONE, 4'b0000, "reset cfg_done");
        expectNow(K_ERR,  4'b0000, "reset cfg_err");
        expectNow(K_CDO,  4'b0000, "reset config_data_out");
        tick();
        nrst = 1'b1;
        tick();

        // XOR config, sweep connection-box selects
        shiftRange(cfgX, 71, 0);
        expectNow(K_DONE, 4'b0001, "cfg_done after 72 bits");
        commitConfig();
        expectNow(K_DONE, 4'b0000, "cfg_done cleared by commit");
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < 4; i++) begin
                cbv[i*4 +: 4] = 4'(s + i);
                expv[i]       = ^(4'(s + i));
            end
            applyStimulus(cbv, ~cbv, 16'h0000, 1'b0);
            expectNow(K_OUT, expv, "xor via sel_cb");
            tick();
        end

        // Same config fed from local interconnect, then per-bit mixing
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < 4; i++) begin
                leiv[i*4 +: 4] = 4'(s + 3 * i);
                expv[i]        = ^(4'(s + 3 * i));
            end
            applyStimulus(~leiv, leiv, 16'hFFFF, 1'b0);
            expectNow(K_OUT, expv, "xor via sel_lei");
            tick();
        end
        for (int m = 0; m < 8; m++) begin
            applyStimulus(mixCb[m], mixLei[m], {4{4'b0101}}, 1'b0);
            expectNow(K_OUT, mixExp[m], "mixed lei_dvn select");
            tick();
        end

        // Registered LE0 with ff_init=1; commit overrides le_en
        applyStimulus(16'h0000, 16'h0000, 16'h0000, 1'b0);
        shiftRange(cfg3, 71, 0);
        applyStimulus(16'h0001, 16'h0000, 16'h0000, 1'b1);
        commitConfig();
        expectNow(K_OUT, 4'b0001, "ff_init loaded on commit");
        expectNow(K_ERR, 4'b0000, "no cfg_err after valid commits");
        applyStimulus(16'h0000, 16'h0000, 16'h0000, 1'b1);
        tick();
        expectNow(K_OUT, 4'b0001, "ff captures lut[0]");
        applyStimulus(16'h0001, 16'h0000, 16'h0000, 1'b0);
        for (int h = 0; h < 10; h++) begin
            expectNow(K_OUT, 4'b0001, "ff holds with le_en=0");
            tick();
        end
        applyStimulus(16'h0001, 16'h0000, 16'h0000, 1'b1);
        expectNow(K_OUT, 4'b0001, "ff before enabled edge");
        tick();
        expectNow(K_OUT, 4'b0000, "ff captures lut[1]");
        tick();

        // Short config: commit rejected, then accepted after the last bit
        applyStimulus(16'h1110, 16'h0000, 16'h0000, 1'b0);
        expectNow(K_OUT, 4'b1110, "le_out before short shift");
        shiftRange(cfgC, 71, 1);
        expectNow(K_DONE, 4'b0000, "cfg_done after 71 bits");
        commitConfig();
        expectNow(K_ERR,  4'b0001, "cfg_err on early commit");
        expectNow(K_DONE, 4'b0000, "cfg_done after rejected commit");
        expectNow(K_OUT,  4'b1110, "le_out unchanged by rejected commit");
        tick();
        expectNow(K_OUT, 4'b1110, "active unchanged by rejected commit");
        shiftRange(cfgC, 0, 0);
        expectNow(K_DONE, 4'b0001, "cfg_done after 72nd bit");
        commitConfig();
        expectNow(K_OUT,  4'b0000, "config C active");
        expectNow(K_ERR,  4'b0001, "cfg_err sticky");
        expectNow(K_DONE, 4'b0000, "cfg_done cleared by late commit");

        // Shift B while C runs, commit during a shift
        applyStimulus(16'h1234, 16'h0000, 16'h0000, 1'b0);
        shiftRange(cfgB, 71, 36);
        expectNow(K_OUT, 4'b0000, "C still active mid-shift");
        shiftRange(cfgB, 35, 0);
        expectNow(K_OUT, 4'b0000, "C still active after shift");
        expectNow(K_CDO, {3'b000, expCdo()}, "config_data_out before commit shift");
        config_en      = 1'b1;
        config_data_in = 1'b1;
        config_commit  = 1'b1;
        sentBits.push_back(1'b1);
        tick();
        config_en     = 1'b0;
        config_commit = 1'b0;
        expectNow(K_OUT,  4'b1111, "config B active after commit+shift");
        expectNow(K_DONE, 4'b0000, "count restarted at 1");
        shiftRange(cfgX, 71, 2);
        expectNow(K_DONE, 4'b0000, "cfg_done at count 71");
        shiftRange(cfgX, 1, 1);
        expectNow(K_DONE, 4'b0001, "cfg_done at count 72");

        // Async reset mid-shift
        shiftRange(cfgX, 71, 42);
        expectNow(K_OUT, 4'b1111, "le_out before reset");
        tick();
        config_en      = 1'b1;
        config_data_in = 1'b1;
        #2;
        nrst = 1'b0;
        sentBits.delete();
        expectNow(K_OUT,  4'b0000, "le_out in async reset");
        expectNow(K_DONE, 4'b0000, "cfg_done in async reset");
        expectNow(K_ERR,  4'b0000, "cfg_err in async reset");
        expectNow(K_CDO,  4'b0000, "config_data_out in async reset");
        tick();
        config_en = 1'b0;
        nrst      = 1'b1;
        tick();
        shiftRange(cfgX, 71, 0);
        commitConfig();
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 4; i++) begin
                cbv[i*4 +: 4] = 4'(5 * s + i + 1);
                expv[i]       = ^(4'(5 * s + i + 1));
            end
            applyStimulus(cbv, 16'h0000, 16'h0000, 1'b0);
            expectNow(K_OUT, expv, "xor after reload");
            tick();
        end

        // Drain the scoreboard with a bounded wait
        wait_n = 0;
        while (qCyc.size() != 0 && wait_n < 5) begin
            tick();
            wait_n++;
        end
        while (qCyc.size() != 0) begin
            nChecks++;
            $display("[TB] FAIL %s: got unchecked expected %b (cycle %0d)", qName[0], qExp[0], qCyc[0]);
            qCyc.delete(0);
            qKind.delete(0);
            qExp.delete(0);
            qName.delete(0);
        end
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
